// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the iterative shift-add multiplier.
//   state_e : controller states (IDLE, RUN, DONE)
//   op_e    : result selection (OP_MUL = low half, OP_UMULH = high half)
//   XZR     : zero register index; writes to it are suppressed
//   ITERATIONS : number of shift-add steps for a full 64-bit multiply
package mult_pkg;

  localparam int ITERATIONS = 64;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL   = 1'b0,
    OP_UMULH = 1'b1
  } op_e;

endpackage

// File: rtl/mult_step.sv
// mult_step: one combinational shift-add multiply step.
//   acc_hi_i  : running partial product (upper half of accumulator)
//   acc_lo_i  : remaining multiplier bits / low product bits
//   a_i       : multiplicand
//   acc_hi_o  : next upper half
//   acc_lo_o  : next lower half
// The 129-bit value {carry, sum, acc_lo} is shifted right by one, so the
// add carry lands in acc_hi[W-1] and sum[0] enters acc_lo[W-1].
module mult_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] acc_hi_i,
  input  logic [W-1:0] acc_lo_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] acc_hi_o,
  output logic [W-1:0] acc_lo_o
);

  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, acc_hi_i} + {1'b0, (acc_lo_i[0] ? a_i : '0)};
    acc_hi_o = sum[W:1];
    acc_lo_o = {sum[0], acc_lo_i[W-1:1]};
  end

endmodule

// File: rtl/iter_multiplier.sv
// iter_multiplier: fixed-latency 64-step shift-add multiplier producing a
// register-file write-back packet.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, honoured only while idle
//   op             : 0 = MUL (product low half), 1 = UMULH (product high half)
//   ReadData1/2    : multiplicand A / multiplier B, captured with start
//   Rd             : destination register, captured with start
//   busy           : high from the accepting edge until the result cycle ends
//   done           : one-cycle result-valid pulse
//   WriteData      : result; holds its value until the next result
//   WriteRegister  : captured Rd; holds like WriteData
//   RegWrite       : pulse with done, suppressed for the zero register
// Every output comes straight from a flop.
module iter_multiplier #(
  parameter int DATA_WIDTH = 64,
  parameter int ITERATIONS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] ReadData1,
  input  logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [4:0]            Rd,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [4:0]            WriteRegister,
  output logic                  RegWrite
);

  import mult_pkg::*;

  localparam int CNT_W = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]      count_q, count_d;
  op_e                   op_q, op_d;
  logic [4:0]            rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  regwrite_q, regwrite_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            wreg_q, wreg_d;

  logic [DATA_WIDTH-1:0] step_hi, step_lo;

  mult_step #(
    .W(DATA_WIDTH)
  ) u_step (
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .a_i      (a_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    count_d    = count_q;
    op_d       = op_q;
    rd_d       = rd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    regwrite_d = 1'b0;
    wdata_d    = wdata_q;
    wreg_d     = wreg_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = ReadData1;
          op_d     = op_e'(op);
          rd_d     = Rd;
          acc_hi_d = '0;
          acc_lo_d = ReadData2;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q + 1'b1;
        // The final step's result is registered straight into the output
        // flops so done and WriteData appear together in the DONE cycle.
        if (count_q == LAST_STEP) begin
          state_d    = DONE;
          done_d     = 1'b1;
          regwrite_d = (rd_q != XZR);
          wdata_d    = (op_q == OP_UMULH) ? step_hi : step_lo;
          wreg_d     = rd_q;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      count_q    <= '0;
      op_q       <= OP_MUL;
      rd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      wdata_q    <= '0;
      wreg_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      count_q    <= count_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      regwrite_q <= regwrite_d;
      wdata_q    <= wdata_d;
      wreg_q     <= wreg_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign RegWrite      = regwrite_q;
  assign WriteData     = wdata_q;
  assign WriteRegister = wreg_q;

endmodule
